// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register file geometry, pipeline slot
// indices, opcode / EXE command encodings and the NOP instruction word.
package mips_pkg;

    localparam int REG_AW    = 5;
    localparam int NUM_SLOTS = 3;

    // Position of each in-flight slot in the slot vectors (youngest first).
    typedef enum logic [1:0] {
        SLOT_EXE = 2'd0,
        SLOT_MEM = 2'd1,
        SLOT_WB  = 2'd2
    } slot_idx_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    typedef enum logic [3:0] {
        EXE_NOP = 4'd0,
        EXE_ADD = 4'd1,
        EXE_SUB = 4'd2,
        EXE_AND = 4'd3,
        EXE_OR  = 4'd4,
        EXE_SLT = 4'd5,
        EXE_LW  = 4'd6,
        EXE_SW  = 4'd7,
        EXE_BR  = 4'd8
    } exe_cmd_e;

    // sll r0, r0, 0 -- what a bubble looks like in ID/EX.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard controller bus: decoded ID fields and pipeline status in,
// pipeline steering out. master = ID/pipeline side, slave = controller.
interface id_hazard_ctrl_if import mips_pkg::*; #(
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_use_src2;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic              br_taken;
    logic              mem_busy;

    logic              hazard_stall;
    logic              pc_en;
    logic              idex_bubble;
    logic              if_flush;
    logic              freeze;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en,
               id_mem_r_en, br_taken, mem_busy,
        input  hazard_stall, pc_en, idex_bubble, if_flush, freeze, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en,
               id_mem_r_en, br_taken, mem_busy,
        output hazard_stall, pc_en, idex_bubble, if_flush, freeze, stall_count
    );

endinterface

// File: rtl/id_hazard_ctrl_slot_pipe.sv
// Three-deep record of register writes in flight (EXE, MEM, WB). Shifts one
// slot per unfrozen edge and reports, per slot, whether it targets a register
// the instruction in ID reads.
module hazard_slot_pipe import mips_pkg::*; #(
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 issue_valid,
    input  logic [REG_AW-1:0]    issue_dest,
    input  logic                 issue_load,
    input  logic [REG_AW-1:0]    src1,
    input  logic [REG_AW-1:0]    src2,
    input  logic                 use_src2,
    output logic [NUM_SLOTS-1:0] match,
    output logic [NUM_SLOTS-1:0] load
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } slot_t;

    slot_t slots [NUM_SLOTS];

    // Register 0 is hard-wired, so a write to it never blocks a reader.
    function automatic logic hit(slot_t s, logic [REG_AW-1:0] r);
        return s.valid && (s.dest == r) && (r != '0);
    endfunction

    // Advance the in-flight record each unfrozen edge; hold while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this slot array is control state whose valid bits must be
            // known after reset, so it is reset like ordinary flops; a data
            // RAM would be left unreset.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (!hold) begin
            // NOTE: non-blocking assignments make all three moves read the
            // pre-edge values, which is what turns this into a shift register.
            slots[SLOT_WB]  <= slots[SLOT_MEM];
            slots[SLOT_MEM] <= slots[SLOT_EXE];
            slots[SLOT_EXE] <= '{valid: issue_valid, dest: issue_dest, is_load: issue_load};
        end
    end

    // Per-slot source-register match and load flag for the stall decision.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch
        // is inferred.
        match = '0;
        load  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = hit(slots[i], src1) | (use_src2 & hit(slots[i], src2));
            load[i]  = slots[i].is_load;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencer for the 5-stage MIPS pipe: RAW stall detection against
// in-flight writes, IF/ID flush after taken branches, whole-pipe freeze on a
// busy data memory, and a saturating count of stall cycles.
module id_hazard_ctrl import mips_pkg::*; #(
    parameter int REG_AW       = mips_pkg::REG_AW,
    parameter int FORWARD_EN   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_hazard_ctrl_if.slave bus
);

    // With forwarding only a load still in EXE cannot be bypassed in time.
    localparam logic [NUM_SLOTS-1:0] EXE_ONLY   = NUM_SLOTS'(1);
    localparam logic [1:0]           FLUSH_LOAD = 2'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

    logic [NUM_SLOTS-1:0] slot_match;
    logic [NUM_SLOTS-1:0] slot_load;
    logic [NUM_SLOTS-1:0] hazard_vec;
    logic                 freeze;
    logic                 hazard_stall;
    logic                 if_flush;
    logic                 issue_valid;
    logic                 br_accept;
    logic [1:0]           flush_cnt;
    logic [CNT_W-1:0]     stall_cnt;

    assign freeze       = bus.mem_busy;
    assign hazard_vec   = (FORWARD_EN != 0) ? (slot_match & slot_load & EXE_ONLY)
                                            : slot_match;
    assign hazard_stall = bus.id_valid & ~freeze & (|hazard_vec);
    assign if_flush     = (flush_cnt != 2'd0);

    // Stalled and flushed instructions never reach EXE, so they never block.
    assign issue_valid  = bus.id_valid & bus.id_wb_en & (bus.id_dest != '0)
                        & ~hazard_stall & ~if_flush;

    // A branch compared during a stall used stale operands, so it is ignored.
    assign br_accept    = bus.br_taken & bus.id_valid & ~hazard_stall & ~freeze;

    hazard_slot_pipe #(.REG_AW(REG_AW)) u_slots (
        .clk         (clk),
        .rst         (rst),
        .hold        (freeze),
        .issue_valid (issue_valid),
        .issue_dest  (bus.id_dest),
        .issue_load  (bus.id_mem_r_en),
        .src1        (bus.id_src1),
        .src2        (bus.id_src2),
        .use_src2    (bus.id_use_src2),
        .match       (slot_match),
        .load        (slot_load)
    );

    // Flush countdown: a taken branch (re)loads it, otherwise it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 2'd0;
        end else if (!freeze) begin
            if (br_accept) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (flush_cnt != 2'd0) begin
                flush_cnt <= flush_cnt - 2'd1;
            end
        end
    end

    // Saturating count of RAW stall cycles (freeze already masks the stall).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.hazard_stall = hazard_stall;
    assign bus.pc_en        = ~freeze & ~hazard_stall;
    assign bus.idex_bubble  = hazard_stall;
    assign bus.if_flush     = if_flush;
    assign bus.freeze       = freeze;
    assign bus.stall_count  = stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: two configurations driven with the same stimulus
// (forwarding/2 flush cycles/16-bit count, and no forwarding/3 flush
// cycles/4-bit count), each compared every cycle against a reference model
// of in-flight writes kept as a short age-ordered history.
module tb_id_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if0 ();
    id_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if1 ();

    id_hazard_ctrl #(.REG_AW(5), .FORWARD_EN(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    id_hazard_ctrl #(.REG_AW(5), .FORWARD_EN(0), .FLUSH_CYCLES(3), .CNT_W(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // Outputs gathered per instance so the model can be written once.
    logic        o_hz  [2];
    logic        o_pc  [2];
    logic        o_bub [2];
    logic        o_fl  [2];
    logic        o_frz [2];
    logic [31:0] o_cnt [2];

    assign o_hz[0]  = if0.hazard_stall;
    assign o_pc[0]  = if0.pc_en;
    assign o_bub[0] = if0.idex_bubble;
    assign o_fl[0]  = if0.if_flush;
    assign o_frz[0] = if0.freeze;
    assign o_cnt[0] = 32'(if0.stall_count);
    assign o_hz[1]  = if1.hazard_stall;
    assign o_pc[1]  = if1.pc_en;
    assign o_bub[1] = if1.idex_bubble;
    assign o_fl[1]  = if1.if_flush;
    assign o_frz[1] = if1.freeze;
    assign o_cnt[1] = 32'(if1.stall_count);

    // Reference model: what each configuration is, and which writes are in
    // flight (age 0 = issued on the last unfrozen edge).
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       ld;
    } wr_t;

    int  fwd_m   [2] = '{1, 0};
    int  flush_m [2] = '{2, 3};
    int  cmax_m  [2] = '{65535, 15};
    wr_t hist    [2][3];
    int  flush_left [2];
    int  cnt_m   [2];

    // Current stimulus, as seen by the model.
    bit       c_v, c_u2, c_we, c_ld, c_br, c_busy;
    bit [4:0] c_s1, c_s2, c_d;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) hist[i][k] = '{v: 1'b0, d: 5'd0, ld: 1'b0};
            flush_left[i] = 0;
            cnt_m[i]      = 0;
        end
    endtask

    // Compare one instance against the model for this cycle, then advance
    // the model across the coming edge.
    task automatic model_cycle(input int i);
        bit  hit, reads, watched, e_stall, e_flush;
        wr_t w;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w       = hist[i][k];
            reads   = (w.d == c_s1) || (c_u2 && (w.d == c_s2));
            watched = (fwd_m[i] == 0) || ((k == 0) && w.ld);
            if (w.v && (w.d != 5'd0) && reads && watched) hit = 1'b1;
        end
        e_stall = c_v && !c_busy && hit;
        e_flush = (flush_left[i] != 0);

        check($sformatf("hazard_stall[%0d]", i), 32'(o_hz[i]),  32'(e_stall));
        check($sformatf("pc_en[%0d]", i),        32'(o_pc[i]),  32'(!c_busy && !e_stall));
        check($sformatf("idex_bubble[%0d]", i),  32'(o_bub[i]), 32'(e_stall));
        check($sformatf("if_flush[%0d]", i),     32'(o_fl[i]),  32'(e_flush));
        check($sformatf("freeze[%0d]", i),       32'(o_frz[i]), 32'(c_busy));
        check($sformatf("stall_count[%0d]", i),  o_cnt[i],      32'(cnt_m[i]));

        if (!c_busy) begin
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = '{v: c_v && c_we && (c_d != 5'd0) && !e_stall && !e_flush,
                           d: c_d, ld: c_ld};
            if (c_br && c_v && !e_stall) flush_left[i] = flush_m[i];
            else if (flush_left[i] > 0)  flush_left[i] = flush_left[i] - 1;
            if (e_stall && (cnt_m[i] < cmax_m[i])) cnt_m[i] = cnt_m[i] + 1;
        end
    endtask

    task automatic drive(input bit v, input bit [4:0] s1, input bit [4:0] s2, input bit u2,
                         input bit [4:0] d, input bit we, input bit ld, input bit br,
                         input bit busy);
        c_v = v; c_s1 = s1; c_s2 = s2; c_u2 = u2; c_d = d;
        c_we = we; c_ld = ld; c_br = br; c_busy = busy;
        if0.id_valid = v;  if0.id_src1 = s1; if0.id_src2 = s2; if0.id_use_src2 = u2;
        if0.id_dest = d;   if0.id_wb_en = we; if0.id_mem_r_en = ld;
        if0.br_taken = br; if0.mem_busy = busy;
        if1.id_valid = v;  if1.id_src1 = s1; if1.id_src2 = s2; if1.id_use_src2 = u2;
        if1.id_dest = d;   if1.id_wb_en = we; if1.id_mem_r_en = ld;
        if1.br_taken = br; if1.mem_busy = busy;
    endtask

    // One pipeline cycle: drive on the falling edge, check just after.
    task automatic step(input bit v, input bit [4:0] s1, input bit [4:0] s2, input bit u2,
                        input bit [4:0] d, input bit we, input bit ld, input bit br,
                        input bit busy);
        @(negedge clk);
        drive(v, s1, s2, u2, d, we, ld, br, busy);
        #1;
        model_cycle(0);
        model_cycle(1);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset state.
        #3;
        for (int i = 0; i < 2; i++) begin
            check("rst_hazard", 32'(o_hz[i]),  32'd0);
            check("rst_pc_en",  32'(o_pc[i]),  32'd1);
            check("rst_bubble", 32'(o_bub[i]), 32'd0);
            check("rst_flush",  32'(o_fl[i]),  32'd0);
            check("rst_count",  o_cnt[i],      32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Load-use: lw r3,0(r1) then add r4,r3,r5.
        step(1, 1, 0, 0, 3, 1, 1, 0, 0);
        step(1, 3, 5, 1, 4, 1, 0, 0, 0);
        check("t1_stall", 32'(o_hz[0]),  32'd1);
        check("t1_bub",   32'(o_bub[0]), 32'd1);
        step(1, 3, 5, 1, 4, 1, 0, 0, 0);
        check("t1_issue", 32'(o_hz[0]),  32'd0);
        check("t1_count", o_cnt[0],      32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // No forwarding: add r2,r7,r8 then sub r6,r2,r1 stalls three cycles.
        step(1, 7, 8, 1, 2, 1, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(1, 2, 1, 1, 6, 1, 0, 0, 0);
            check("t2_stall", 32'(o_hz[1]), 32'd1);
        end
        step(1, 2, 1, 1, 6, 1, 0, 0, 0);
        check("t2_issue", 32'(o_hz[1]), 32'd0);

        // Register 0 and an unused src2.
        step(1, 1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 5, 1, 0, 0, 0);
        check("t3_r0", 32'(o_hz[1]), 32'd0);
        step(1, 1, 0, 0, 9, 1, 1, 0, 0);
        step(1, 1, 9, 0, 10, 1, 0, 0, 0);
        check("t3_src2_fwd",  32'(o_hz[0]), 32'd0);
        check("t3_src2_nfwd", 32'(o_hz[1]), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Taken branch, then two wrong-path writers to r11, then a reader of r11.
        step(1, 20, 21, 1, 0, 0, 0, 1, 0);
        for (int n = 0; n < 2; n++) begin
            step(1, 22, 0, 0, 11, 1, 0, 0, 0);
            check("t4_flush", 32'(o_fl[0]), 32'd1);
            check("t4_pc_en", 32'(o_pc[0]), 32'd1);
        end
        step(1, 11, 0, 0, 12, 1, 0, 0, 0);
        check("t4_done", 32'(o_fl[0]), 32'd0);
        check("t4_nocarry", 32'(o_hz[1]), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Freeze during a load-use: lw r13, then add r14,r13 with memory busy.
        step(1, 1, 0, 0, 13, 1, 1, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(1, 13, 0, 0, 14, 1, 0, 0, 1);
            check("t5_frozen", 32'(o_pc[0]), 32'd0);
        end
        step(1, 13, 0, 0, 14, 1, 0, 0, 0);
        check("t5_resume", 32'(o_hz[0]), 32'd1);
        step(1, 13, 0, 0, 14, 1, 0, 0, 0);
        check("t5_issue", 32'(o_hz[0]), 32'd0);

        // Async reset between edges with writes in flight and a flush pending.
        step(1, 1, 0, 0, 15, 1, 1, 0, 0);
        step(1, 1, 0, 0, 16, 1, 0, 0, 0);
        step(1, 20, 21, 1, 0, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check("t6_flush", 32'(o_fl[i]),  32'd0);
            check("t6_count", o_cnt[i],      32'd0);
            check("t6_pc_en", 32'(o_pc[i]),  32'd1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1, 16, 15, 1, 17, 1, 0, 0, 0);
        check("t6_noblock", 32'(o_hz[1]), 32'd0);

        // Randomized traffic over a small register set so hazards are common.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0,
                 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                 $urandom_range(0, 1) != 0,
                 5'($urandom_range(0, 4)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
